// File: rtl/cpu_defs.sv
// Shared pipeline definitions for the Execute -> Memory1 -> Memory2 path.
// Holds the inter-stage bundles, the forwarding request, the access-size
// enum, the exception event record and the exception code constants.
package cpu_defs;

    // Exception code raised when a load/store address is misaligned
    localparam logic [5:0] ECODE_ALE = 6'h09;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF_WORD = 2'd1,
        WORD      = 2'd2
    } byte_type_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] badv;
    } excp_event_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic [31:0] ex_out;
        logic        is_mem;
        logic        is_store;
        logic        is_signed;
        byte_type_t  byte_type;
        logic [31:0] pa;
        logic [31:0] st_data;
        excp_event_t excp_event;
    } execute_memory1_pass_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic        is_wr_rd_pc_plus4;
        logic [31:0] ex_out;
        logic        is_mem;
        logic        is_store;
        logic        is_signed;
        byte_type_t  byte_type;
        logic [31:0] pa;
        logic [31:0] st_data;
        excp_event_t excp_event;
        logic        dcache_wait_resp;
        logic [1:0]  byte_en;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic        data_valid;
        logic [31:0] data;
    } forward_req_t;

endpackage

// File: rtl/mem_align_unit.sv
// Combinational alignment helper for the Memory1 stage.
// Ports:
//   byte_type - access size (BYTE / HALF_WORD / WORD)
//   addr_lo   - low two bits of the physical address
//   st_data   - raw store data from Execute (value in the low bits)
//   is_store  - access is a store (strobes are zero for loads)
//   misalign  - address is not naturally aligned for the access size
//   wstrb     - byte strobes for the addressed word
//   wdata     - store data replicated across all byte lanes
module mem_align_unit
    import cpu_defs::*;
(
    input  byte_type_t  byte_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic        is_store,
    output logic        misalign,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    logic [3:0] strobe;

    // Replicating the data into every lane lets the cache pick the bytes
    // with the strobes alone, without a shifter keyed on the address.
    always_comb begin
        misalign = 1'b0;
        strobe   = 4'b1111;
        wdata    = st_data;
        case (byte_type)
            BYTE: begin
                strobe = 4'b0001 << addr_lo;
                wdata  = {4{st_data[7:0]}};
            end
            HALF_WORD: begin
                misalign = addr_lo[0];
                strobe   = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{st_data[15:0]}};
            end
            default: begin
                misalign = |addr_lo;
                strobe   = 4'b1111;
                wdata    = st_data;
            end
        endcase
        wstrb = is_store ? strobe : 4'b0000;
    end

endmodule

// File: rtl/memory1_stage.sv
// First memory pipeline stage, between Execute and Memory2.
// Registers the Execute bundle, checks load/store alignment, issues at most
// one dcache request per instruction and builds the Memory2 bundle plus a
// forwarding request for the issue stage.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   flush_i             - pipeline flush
//   stall_i / stall_o   - stall from Memory2 / stall to Execute
//   pass_in / pass_out  - Execute bundle in / Memory2 bundle out
//   fwd_req             - forwarding request (valid, idx, data_valid, data)
//   dcache_req_*        - dcache request handshake and payload
//   dcache_req_cancel   - drop an already accepted request on flush
module memory1_stage
    import cpu_defs::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  stall_i,
    output logic                  stall_o,
    input  execute_memory1_pass_t pass_in,
    output memory1_memory2_pass_t pass_out,
    output forward_req_t          fwd_req,
    output logic                  dcache_req_valid,
    input  logic                  dcache_req_ready,
    output logic [31:0]           dcache_req_addr,
    output logic                  dcache_req_is_store,
    output logic [3:0]            dcache_req_wstrb,
    output logic [31:0]           dcache_req_wdata,
    output logic                  dcache_req_cancel
);

    execute_memory1_pass_t pass_in_r;
    logic                  req_sent;
    logic                  has_excp;
    logic                  eu_do;
    logic                  mem_op;
    logic                  misalign;
    logic                  handshake;

    mem_align_unit u_align (
        .byte_type (pass_in_r.byte_type),
        .addr_lo   (pass_in_r.pa[1:0]),
        .st_data   (pass_in_r.st_data),
        .is_store  (pass_in_r.is_store),
        .misalign  (misalign),
        .wstrb     (dcache_req_wstrb),
        .wdata     (dcache_req_wdata)
    );

    assign has_excp  = pass_in_r.excp_event.valid;
    assign eu_do     = pass_in_r.valid & ~has_excp;
    assign mem_op    = eu_do & pass_in_r.is_mem;
    assign handshake = dcache_req_valid & dcache_req_ready;

    // A request already accepted during a downstream stall must not be
    // re-issued, so req_sent masks the valid until the stage moves on.
    assign dcache_req_valid    = mem_op & ~misalign & ~req_sent & ~flush_i;
    assign dcache_req_addr     = {pass_in_r.pa[31:2], 2'b00};
    assign dcache_req_is_store = pass_in_r.is_store;
    assign dcache_req_cancel   = flush_i & req_sent;
    assign stall_o             = stall_i | (dcache_req_valid & ~dcache_req_ready);

    // Stage register: a flush always replaces the content, even under stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_in_r <= '0;
        end else if (~stall_o | flush_i) begin
            pass_in_r <= pass_in;
        end
    end

    // Remembers an accepted request while the instruction is held in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_sent <= 1'b0;
        end else if (flush_i) begin
            req_sent <= 1'b0;
        end else if (handshake & stall_o) begin
            req_sent <= 1'b1;
        end else if (~stall_o) begin
            req_sent <= 1'b0;
        end
    end

    // Memory2 bundle; misaligned accesses are converted into an ALE event.
    always_comb begin
        pass_out.valid             = pass_in_r.valid & ~stall_o & ~flush_i;
        pass_out.pc                = pass_in_r.pc;
        pass_out.pc_plus4          = pass_in_r.pc_plus4;
        pass_out.rd                = pass_in_r.rd;
        pass_out.is_wr_rd          = pass_in_r.is_wr_rd;
        pass_out.is_wr_rd_pc_plus4 = pass_in_r.is_wr_rd_pc_plus4;
        pass_out.ex_out            = pass_in_r.ex_out;
        pass_out.is_mem            = pass_in_r.is_mem;
        pass_out.is_store          = pass_in_r.is_store;
        pass_out.is_signed         = pass_in_r.is_signed;
        pass_out.byte_type         = pass_in_r.byte_type;
        pass_out.pa                = pass_in_r.pa;
        pass_out.st_data           = pass_in_r.st_data;
        pass_out.excp_event        = pass_in_r.excp_event;
        if (mem_op & misalign) begin
            pass_out.excp_event.valid    = 1'b1;
            pass_out.excp_event.ecode    = ECODE_ALE;
            pass_out.excp_event.esubcode = 9'd0;
            pass_out.excp_event.badv     = pass_in_r.pa;
        end
        pass_out.dcache_wait_resp = mem_op & ~misalign & (req_sent | handshake);
        pass_out.byte_en          = pass_in_r.pa[1:0];
    end

    // Load results only arrive in Memory2, so loads forward without data
    // and the issue stage inserts a load-use stall.
    always_comb begin
        fwd_req.valid      = eu_do & pass_in_r.is_wr_rd & (pass_in_r.rd != 5'd0);
        fwd_req.idx        = pass_in_r.rd;
        fwd_req.data_valid = ~(pass_in_r.is_mem & ~pass_in_r.is_store);
        fwd_req.data       = pass_in_r.is_wr_rd_pc_plus4 ? pass_in_r.pc_plus4
                                                          : pass_in_r.ex_out;
    end

endmodule

// File: tb/tb_memory1_stage.sv
// Self-checking bench for memory1_stage: a table of single-cycle vectors
// fed through a scoreboard queue, then hand-written multi-cycle sequences
// for backpressure, downstream stall, flush-after-accept and flush of a
// pending request.
module tb_memory1_stage;
    import cpu_defs::*;

    logic                  clk;
    logic                  rst_n;
    logic                  flush_i;
    logic                  stall_i;
    logic                  stall_o;
    execute_memory1_pass_t pin;
    memory1_memory2_pass_t pass_out;
    forward_req_t          fwd_req;
    logic                  dcache_req_valid;
    logic                  dcache_req_ready;
    logic [31:0]           dcache_req_addr;
    logic                  dcache_req_is_store;
    logic [3:0]            dcache_req_wstrb;
    logic [31:0]           dcache_req_wdata;
    logic                  dcache_req_cancel;

    memory1_stage dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush_i             (flush_i),
        .stall_i             (stall_i),
        .stall_o             (stall_o),
        .pass_in             (pin),
        .pass_out            (pass_out),
        .fwd_req             (fwd_req),
        .dcache_req_valid    (dcache_req_valid),
        .dcache_req_ready    (dcache_req_ready),
        .dcache_req_addr     (dcache_req_addr),
        .dcache_req_is_store (dcache_req_is_store),
        .dcache_req_wstrb    (dcache_req_wstrb),
        .dcache_req_wdata    (dcache_req_wdata),
        .dcache_req_cancel   (dcache_req_cancel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        req_valid;
        logic [31:0] addr;
        logic        is_store;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        pass_valid;
        logic        wait_resp;
        logic [1:0]  byte_en;
        logic        ev;
        logic [5:0]  ecode;
        logic [31:0] badv;
        logic        fv;
        logic [4:0]  idx;
        logic        dv;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        execute_memory1_pass_t stim;
        exp_t                  want;
    } vec_t;

    localparam int NVEC = 12;

    vec_t                  vec [NVEC];
    exp_t                  exp_q [$];
    execute_memory1_pass_t bubble;
    int                    total;
    int                    bad;
    int                    hs_count;
    int                    hs_base;

    function automatic execute_memory1_pass_t mkOp(
        input logic [31:0] pc, input byte_type_t bt, input logic [31:0] pa,
        input logic [31:0] st, input logic is_mem, input logic is_store,
        input logic [4:0] rd, input logic wr, input logic pc4sel,
        input logic [31:0] ex_out);
        execute_memory1_pass_t p;
        p                   = '0;
        p.valid             = 1'b1;
        p.pc                = pc;
        p.pc_plus4          = pc + 32'd4;
        p.rd                = rd;
        p.is_wr_rd          = wr;
        p.is_wr_rd_pc_plus4 = pc4sel;
        p.ex_out            = ex_out;
        p.is_mem            = is_mem;
        p.is_store          = is_store;
        p.byte_type         = bt;
        p.pa                = pa;
        p.st_data           = st;
        return p;
    endfunction

    function automatic exp_t mkExp(
        input int id, input logic [31:0] pc, input logic req,
        input logic [31:0] addr, input logic st, input logic [3:0] wstrb,
        input logic [31:0] wdata, input logic pv, input logic wt,
        input logic [1:0] be, input logic ev, input logic [5:0] ecode,
        input logic [31:0] badv, input logic fv, input logic [4:0] idx,
        input logic dv, input logic [31:0] data);
        exp_t e;
        e.id = id;        e.pc = pc;        e.req_valid = req;
        e.addr = addr;    e.is_store = st;  e.wstrb = wstrb;
        e.wdata = wdata;  e.pass_valid = pv; e.wait_resp = wt;
        e.byte_en = be;   e.ev = ev;        e.ecode = ecode;
        e.badv = badv;    e.fv = fv;        e.idx = idx;
        e.dv = dv;        e.data = data;
        return e;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act,
                              input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, act, want);
        end
    endtask

    // Drive one table vector and queue the result expected one cycle later.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        pin              = v.stim;
        stall_i          = 1'b0;
        dcache_req_ready = 1'b1;
        flush_i          = 1'b0;
        exp_q.push_back(v.want);
        #1;
    endtask

    // Compare the instruction currently held in the stage against the queue.
    task automatic checkOutput();
        exp_t  e;
        string n;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard: got=empty want=entry");
            return;
        end
        total--;
        e = exp_q.pop_front();
        n = $sformatf("v%0d", e.id);
        checkValue({n, ".pc"},         pass_out.pc,               e.pc);
        checkValue({n, ".pass_valid"}, 32'(pass_out.valid),       32'(e.pass_valid));
        checkValue({n, ".wait_resp"},  32'(pass_out.dcache_wait_resp), 32'(e.wait_resp));
        checkValue({n, ".byte_en"},    32'(pass_out.byte_en),     32'(e.byte_en));
        checkValue({n, ".excp_valid"}, 32'(pass_out.excp_event.valid), 32'(e.ev));
        checkValue({n, ".ecode"},      32'(pass_out.excp_event.ecode),  32'(e.ecode));
        checkValue({n, ".badv"},       pass_out.excp_event.badv,  e.badv);
        checkValue({n, ".fwd_valid"},  32'(fwd_req.valid),        32'(e.fv));
        checkValue({n, ".fwd_idx"},    32'(fwd_req.idx),          32'(e.idx));
        checkValue({n, ".fwd_dv"},     32'(fwd_req.data_valid),   32'(e.dv));
        checkValue({n, ".fwd_data"},   fwd_req.data,              e.data);
        checkValue({n, ".stall_o"},    32'(stall_o),              32'd0);
        checkValue({n, ".req_valid"},  32'(dcache_req_valid),     32'(e.req_valid));
        if (e.req_valid) begin
            checkValue({n, ".addr"},     dcache_req_addr,           e.addr);
            checkValue({n, ".is_store"}, 32'(dcache_req_is_store),  32'(e.is_store));
            checkValue({n, ".wstrb"},    32'(dcache_req_wstrb),     32'(e.wstrb));
            checkValue({n, ".wdata"},    dcache_req_wdata,          e.wdata);
        end
        if (e.ev && e.ecode == ECODE_ALE)
            checkValue({n, ".esubcode"}, 32'(pass_out.excp_event.esubcode), 32'd0);
    endtask

    // One cycle of hand-driven stimulus; outputs are sampled 1 ns later.
    task automatic stepCycle(input execute_memory1_pass_t p, input logic st,
                             input logic rdy, input logic fl);
        @(negedge clk);
        pin              = p;
        stall_i          = st;
        dcache_req_ready = rdy;
        flush_i          = fl;
        #1;
        if (dcache_req_valid && dcache_req_ready) hs_count++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        execute_memory1_pass_t lw_a, alu_b, lw_c, lw_d, lw_e, lw_f;
        total    = 0;
        bad      = 0;
        hs_count = 0;
        bubble   = '0;

        vec[0].stim  = mkOp(32'h100, WORD, 32'h1000_0004, 32'hDEAD_BEEF, 1, 1, 0, 0, 0, 32'h1000_0004);
        vec[0].want  = mkExp(0, 32'h100, 1, 32'h1000_0004, 1, 4'hF, 32'hDEAD_BEEF, 1, 1, 2'd0, 0, 0, 0, 0, 0, 1, 32'h1000_0004);
        vec[1].stim  = mkOp(32'h104, BYTE, 32'h1000_0003, 32'h0000_0012, 1, 1, 0, 0, 0, 32'h1000_0003);
        vec[1].want  = mkExp(1, 32'h104, 1, 32'h1000_0000, 1, 4'h8, 32'h1212_1212, 1, 1, 2'd3, 0, 0, 0, 0, 0, 1, 32'h1000_0003);
        vec[2].stim  = mkOp(32'h108, HALF_WORD, 32'h1000_0002, 32'h0, 1, 0, 5, 1, 0, 32'h1000_0002);
        vec[2].want  = mkExp(2, 32'h108, 1, 32'h1000_0000, 0, 4'h0, 32'h0, 1, 1, 2'd2, 0, 0, 0, 1, 5, 0, 32'h1000_0002);
        vec[3].stim  = mkOp(32'h10C, WORD, 32'h1000_0006, 32'h0, 1, 0, 0, 1, 0, 32'h1000_0006);
        vec[3].want  = mkExp(3, 32'h10C, 0, 0, 0, 0, 0, 1, 0, 2'd2, 1, 6'h09, 32'h1000_0006, 0, 0, 0, 32'h1000_0006);
        vec[4].stim  = mkOp(32'h110, HALF_WORD, 32'h1000_000A, 32'h0000_BEEF, 1, 1, 0, 0, 0, 32'h1000_000A);
        vec[4].want  = mkExp(4, 32'h110, 1, 32'h1000_0008, 1, 4'hC, 32'hBEEF_BEEF, 1, 1, 2'd2, 0, 0, 0, 0, 0, 1, 32'h1000_000A);
        vec[5].stim  = mkOp(32'h114, HALF_WORD, 32'h1000_0001, 32'h0000_1234, 1, 1, 0, 0, 0, 32'h1000_0001);
        vec[5].want  = mkExp(5, 32'h114, 0, 0, 0, 0, 0, 1, 0, 2'd1, 1, 6'h09, 32'h1000_0001, 0, 0, 1, 32'h1000_0001);
        vec[6].stim  = mkOp(32'h118, WORD, 32'h0000_0003, 32'h0, 0, 0, 3, 1, 0, 32'h0000_0055);
        vec[6].want  = mkExp(6, 32'h118, 0, 0, 0, 0, 0, 1, 0, 2'd3, 0, 0, 0, 1, 3, 1, 32'h0000_0055);
        vec[7].stim  = mkOp(32'h11C, WORD, 32'h0, 32'h0, 0, 0, 1, 1, 1, 32'h0000_0999);
        vec[7].want  = mkExp(7, 32'h11C, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 1, 1, 1, 32'h0000_0120);
        vec[8].stim  = mkOp(32'h120, WORD, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h0000_0077);
        vec[8].want  = mkExp(8, 32'h120, 0, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 1, 32'h0000_0077);
        vec[9].stim  = mkOp(32'h124, WORD, 32'h1000_0010, 32'h0, 1, 0, 4, 1, 0, 32'h1000_0010);
        vec[9].stim.excp_event.valid = 1'b1;
        vec[9].stim.excp_event.ecode = 6'h05;
        vec[9].stim.excp_event.badv  = 32'h0000_00AA;
        vec[9].want  = mkExp(9, 32'h124, 0, 0, 0, 0, 0, 1, 0, 2'd0, 1, 6'h05, 32'h0000_00AA, 0, 4, 0, 32'h1000_0010);
        vec[10].stim = mkOp(32'h128, BYTE, 32'h1000_0007, 32'h0, 1, 0, 9, 1, 0, 32'h1000_0007);
        vec[10].want = mkExp(10, 32'h128, 1, 32'h1000_0004, 0, 4'h0, 32'h0, 1, 1, 2'd3, 0, 0, 0, 1, 9, 0, 32'h1000_0007);
        vec[11].stim = mkOp(32'h12C, BYTE, 32'h1000_0001, 32'hFFFF_FFAB, 1, 1, 0, 0, 0, 32'h1000_0001);
        vec[11].want = mkExp(11, 32'h12C, 1, 32'h1000_0000, 1, 4'h2, 32'hABAB_ABAB, 1, 1, 2'd1, 0, 0, 0, 0, 0, 1, 32'h1000_0001);

        // Reset with a valid instruction presented: nothing may come out.
        rst_n            = 1'b0;
        flush_i          = 1'b0;
        stall_i          = 1'b0;
        dcache_req_ready = 1'b1;
        pin              = vec[0].stim;
        repeat (2) @(negedge clk);
        #1;
        checkValue("rst.req_valid",  32'(dcache_req_valid),  32'd0);
        checkValue("rst.stall_o",    32'(stall_o),           32'd0);
        checkValue("rst.cancel",     32'(dcache_req_cancel), 32'd0);
        checkValue("rst.fwd_valid",  32'(fwd_req.valid),     32'd0);
        checkValue("rst.pass_valid", 32'(pass_out.valid),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pin   = bubble;

        // Table vectors, one per cycle, checked one cycle after they are driven.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vec[i]);
            if (i > 0) checkOutput();
        end
        stepCycle(bubble, 0, 1, 0);
        checkOutput();

        // Backpressure: ready low for three cycles on an aligned load.
        lw_a  = mkOp(32'h200, WORD, 32'h2000_0000, 32'h0, 1, 0, 6, 1, 0, 32'h2000_0000);
        alu_b = mkOp(32'h204, WORD, 32'h0, 32'h0, 0, 0, 2, 1, 0, 32'h0000_0042);
        stepCycle(lw_a, 0, 0, 0);
        hs_base = hs_count;
        for (int c = 0; c < 3; c++) begin
            stepCycle(alu_b, 0, 0, 0);
            checkValue($sformatf("bp%0d.stall_o", c),   32'(stall_o),          32'd1);
            checkValue($sformatf("bp%0d.req_valid", c), 32'(dcache_req_valid), 32'd1);
            checkValue($sformatf("bp%0d.addr", c),      dcache_req_addr,       32'h2000_0000);
            checkValue($sformatf("bp%0d.wstrb", c),     32'(dcache_req_wstrb), 32'd0);
            checkValue($sformatf("bp%0d.pass_valid", c), 32'(pass_out.valid),  32'd0);
        end
        stepCycle(alu_b, 0, 1, 0);
        checkValue("bp.accept_stall_o", 32'(stall_o),                   32'd0);
        checkValue("bp.accept_valid",   32'(pass_out.valid),            32'd1);
        checkValue("bp.accept_wait",    32'(pass_out.dcache_wait_resp), 32'd1);
        checkValue("bp.accept_pc",      pass_out.pc,                    32'h200);
        stepCycle(bubble, 0, 1, 0);
        checkValue("bp.next_pc",        pass_out.pc,                    32'h204);
        checkValue("bp.next_req_valid", 32'(dcache_req_valid),          32'd0);
        checkValue("bp.handshakes",     32'(hs_count - hs_base),        32'd1);

        // Accepted while Memory2 stalls: no re-issue, wait_resp held.
        lw_c = mkOp(32'h300, WORD, 32'h3000_0008, 32'h0, 1, 0, 8, 1, 0, 32'h3000_0008);
        stepCycle(lw_c, 0, 1, 0);
        hs_base = hs_count;
        stepCycle(bubble, 1, 1, 0);
        checkValue("st.hs_req_valid", 32'(dcache_req_valid),          32'd1);
        checkValue("st.hs_stall_o",   32'(stall_o),                   32'd1);
        checkValue("st.hs_wait",      32'(pass_out.dcache_wait_resp), 32'd1);
        stepCycle(bubble, 1, 1, 0);
        checkValue("st.held_req_valid", 32'(dcache_req_valid),          32'd0);
        checkValue("st.held_wait",      32'(pass_out.dcache_wait_resp), 32'd1);
        checkValue("st.held_cancel",    32'(dcache_req_cancel),         32'd0);
        checkValue("st.held_valid",     32'(pass_out.valid),            32'd0);
        stepCycle(bubble, 0, 1, 0);
        checkValue("st.go_req_valid", 32'(dcache_req_valid),          32'd0);
        checkValue("st.go_valid",     32'(pass_out.valid),            32'd1);
        checkValue("st.go_wait",      32'(pass_out.dcache_wait_resp), 32'd1);
        checkValue("st.go_pc",        pass_out.pc,                    32'h300);
        checkValue("st.handshakes",   32'(hs_count - hs_base),        32'd1);

        // Flush the cycle after an accept under stall: cancel, then reload.
        lw_d = mkOp(32'h400, WORD, 32'h4000_0000, 32'h0, 1, 0, 10, 1, 0, 32'h4000_0000);
        lw_e = mkOp(32'h500, WORD, 32'h5000_0004, 32'h0, 1, 0, 11, 1, 0, 32'h5000_0004);
        stepCycle(lw_d, 0, 1, 0);
        stepCycle(bubble, 1, 1, 0);
        checkValue("fl.hs_req_valid", 32'(dcache_req_valid), 32'd1);
        stepCycle(lw_e, 1, 1, 1);
        checkValue("fl.cancel",     32'(dcache_req_cancel), 32'd1);
        checkValue("fl.pass_valid", 32'(pass_out.valid),    32'd0);
        checkValue("fl.req_valid",  32'(dcache_req_valid),  32'd0);
        stepCycle(bubble, 0, 1, 0);
        checkValue("fl.after_cancel",    32'(dcache_req_cancel), 32'd0);
        checkValue("fl.after_pc",        pass_out.pc,            32'h500);
        checkValue("fl.after_req_valid", 32'(dcache_req_valid),  32'd1);
        checkValue("fl.after_addr",      dcache_req_addr,        32'h5000_0004);
        checkValue("fl.after_valid",     32'(pass_out.valid),    32'd1);

        // Flush while a request is still waiting for ready: it just vanishes.
        lw_f = mkOp(32'h600, WORD, 32'h6000_0000, 32'h0, 1, 0, 12, 1, 0, 32'h6000_0000);
        stepCycle(lw_f, 0, 0, 0);
        hs_base = hs_count;
        stepCycle(bubble, 0, 0, 1);
        checkValue("fp.req_valid",  32'(dcache_req_valid),  32'd0);
        checkValue("fp.cancel",     32'(dcache_req_cancel), 32'd0);
        checkValue("fp.pass_valid", 32'(pass_out.valid),    32'd0);
        checkValue("fp.stall_o",    32'(stall_o),           32'd0);
        stepCycle(bubble, 0, 1, 0);
        checkValue("fp.after_valid",     32'(pass_out.valid),   32'd0);
        checkValue("fp.after_req_valid", 32'(dcache_req_valid), 32'd0);
        checkValue("fp.handshakes",      32'(hs_count - hs_base), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
